axis_wrr_port_scheduler: RTL and testbench

//  Packet-level weighted round-robin scheduler that shares the switch datapath between NUM_PORTS AXI4-Stream ingress

---
 rtl/axis_wrr_port_scheduler_if.sv | 34 +++
 rtl/axis_wrr_port_scheduler.sv | 112 +++++++++++
 tb/tb_axis_wrr_port_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_wrr_port_scheduler_if.sv
// Stream bundle between the ingress FIFOs, the WRR scheduler and output_port_lookup.
// Ingress lane i occupies slice [i*W +: W] of every s_axis_* vector.
interface axis_wrr_port_scheduler_if #(
    parameter int NUM_PORTS    = 5,
    parameter int C_DATA_WIDTH = 512,
    parameter int C_USER_WIDTH = 128
);
    localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;

    logic [NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep;
    logic [NUM_PORTS*C_USER_WIDTH-1:0] s_axis_tuser;
    logic [NUM_PORTS-1:0]              s_axis_tvalid;
    logic [NUM_PORTS-1:0]              s_axis_tlast;
    logic [NUM_PORTS-1:0]              s_axis_tready;

    logic [C_DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_WIDTH-1:0]             m_axis_tkeep;
    logic [C_USER_WIDTH-1:0]           m_axis_tuser;
    logic                              m_axis_tvalid;
    logic                              m_axis_tlast;
    logic                              m_axis_tready;

    // master: the traffic around the scheduler (ingress sources, egress sink); slave: the scheduler
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/axis_wrr_port_scheduler.sv
// Packet-level weighted round-robin scheduler: grants one ingress port a burst of up to
// weights[i] whole packets, then rotates to the next eligible port. Keeps per-port packet counts.
module axis_wrr_port_scheduler #(
    parameter int NUM_PORTS    = 5,
    parameter int C_DATA_WIDTH = 512,
    parameter int C_USER_WIDTH = 128,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_rst,
    axis_wrr_port_scheduler_if.slave          axis,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weights,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_id,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]    pkt_cnt
);
    localparam int KEEP_WIDTH = C_DATA_WIDTH / 8;
    localparam int ID_WIDTH   = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, PKT} state_t;

    state_t                  state, state_nxt;
    logic [ID_WIDTH-1:0]     ptr, ptr_nxt;
    logic [WEIGHT_WIDTH-1:0] burst, burst_nxt;
    logic                    pkt_done;
    logic [NUM_PORTS-1:0]    eligible;

    logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0] wt;
    logic [NUM_PORTS-1:0][C_DATA_WIDTH-1:0] s_data;
    logic [NUM_PORTS-1:0][KEEP_WIDTH-1:0]   s_keep;
    logic [NUM_PORTS-1:0][C_USER_WIDTH-1:0] s_user;

    assign wt     = weights;
    assign s_data = axis.s_axis_tdata;
    assign s_keep = axis.s_axis_tkeep;
    assign s_user = axis.s_axis_tuser;

    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_PORTS) s -= NUM_PORTS;
        return s[ID_WIDTH-1:0];
    endfunction

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state <= IDLE;
            ptr   <= '0;
            burst <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            burst <= burst_nxt;
        end
    end

    // Arbitration sees only registered ptr/burst plus tvalid and weights; m_axis_tready never reaches it.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        burst_nxt = burst;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = PKT;
                    if (!(eligible[ptr] && (burst < wt[ptr]))) begin
                        burst_nxt = '0;
                        // Descending scan: the nearest eligible port after ptr is written last; ptr itself is k=NUM_PORTS.
                        for (int k = NUM_PORTS; k >= 1; k--) begin
                            if (eligible[wrap_add(ptr, k)]) ptr_nxt = wrap_add(ptr, k);
                        end
                    end
                end
            end
            PKT: begin
                if (pkt_done) begin
                    state_nxt = IDLE;
                    burst_nxt = (&burst) ? burst : burst + WEIGHT_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axis.s_axis_tready = '0;
        if (state == PKT) axis.s_axis_tready[ptr] = axis.m_axis_tready;
    end

    assign axis.m_axis_tvalid = (state == PKT) && axis.s_axis_tvalid[ptr];
    assign axis.m_axis_tdata  = s_data[ptr];
    assign axis.m_axis_tkeep  = s_keep[ptr];
    assign axis.m_axis_tuser  = s_user[ptr];
    assign axis.m_axis_tlast  = axis.s_axis_tlast[ptr];
    assign pkt_done           = axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast;

    // ptr always equals the most recent grant, so it doubles as grant_id.
    assign grant_id = ptr;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [CNT_WIDTH-1:0] cnt;

        assign eligible[i] = axis.s_axis_tvalid[i] & (|wt[i]);

        always_ff @(posedge axis_aclk or posedge axis_rst) begin
            if (axis_rst)                          cnt <= '0;
            else if (pkt_done && ptr == ID_WIDTH'(i)) cnt <= cnt + CNT_WIDTH'(1);
        end

        assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end
endmodule

// File: tb/tb_axis_wrr_port_scheduler.sv
// Randomized bench for the WRR scheduler: per-port packet queues feed both the drivers and a
// queue-level WRR model whose predicted egress beats are checked by an independent monitor.
module tb_axis_wrr_port_scheduler;
    localparam int NP = 5;
    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int WW = 4;
    localparam int CW = 4;
    localparam int IW = $clog2(NP);

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            port;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NP*WW-1:0] weights = '0;
    logic [IW-1:0]  grant_id;
    logic [NP*CW-1:0] pkt_cnt;

    int total = 0, bad = 0, cyc = 0, beats_seen = 0, prev_cyc = -1, w2_viol = 0;
    int tr_mode = 0, next_id = 0;
    bit bub_en = 0, gap_chk = 0, w2_chk = 0;

    beat_t sb[$];
    beat_t mon_e;
    int drv_id[NP][$];
    int drv_len[NP][$];
    int mdl_id[NP][$];
    int mdl_len[NP][$];
    int beat_idx[NP];
    bit bubble[NP];
    int m_cnt[NP];
    int wv[NP];
    int m_ptr = 0, m_burst = 0;

    axis_wrr_port_scheduler_if #(.NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_USER_WIDTH(UW)) bus ();

    axis_wrr_port_scheduler #(
        .NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_USER_WIDTH(UW), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)
    ) dut (
        .axis_aclk(clk),
        .axis_rst (rst),
        .axis     (bus),
        .weights  (weights),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int p, input int id, input int b);
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++)
            d[j*32 +: 32] = (32'(p) * 32'h9E3779B1) ^ (32'(id) * 32'h85EBCA6B) ^ (32'(b * 64 + j) * 32'hC2B2AE35);
        return d;
    endfunction

    function automatic logic [UW-1:0] mk_user(input int p, input int id, input int b);
        logic [UW-1:0] u;
        for (int j = 0; j < UW / 32; j++)
            u[j*32 +: 32] = (32'(p + 7) * 32'h27D4EB2F) ^ (32'(id) * 32'h165667B1) ^ 32'(b * 16 + j);
        return u;
    endfunction

    function automatic logic [KW-1:0] mk_keep(input int id, input bit last);
        logic [KW-1:0] k;
        k = '1;
        if (last) k = k >> (id % 16);
        return k;
    endfunction

    task automatic drive_all();
        for (int p = 0; p < NP; p++) begin
            if (drv_len[p].size() > 0 && !bubble[p]) begin
                bus.s_axis_tvalid[p]             = 1'b1;
                bus.s_axis_tlast[p]              = (beat_idx[p] == drv_len[p][0] - 1);
                bus.s_axis_tdata[p*DW +: DW]     = mk_data(p, drv_id[p][0], beat_idx[p]);
                bus.s_axis_tuser[p*UW +: UW]     = mk_user(p, drv_id[p][0], beat_idx[p]);
                bus.s_axis_tkeep[p*KW +: KW]     = mk_keep(drv_id[p][0], beat_idx[p] == drv_len[p][0] - 1);
            end else begin
                bus.s_axis_tvalid[p]             = 1'b0;
                bus.s_axis_tlast[p]              = 1'b0;
                bus.s_axis_tdata[p*DW +: DW]     = '0;
                bus.s_axis_tuser[p*UW +: UW]     = '0;
                bus.s_axis_tkeep[p*KW +: KW]     = '0;
            end
        end
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d, input int e);
        wv[0] = a; wv[1] = b; wv[2] = c; wv[3] = d; wv[4] = e;
        for (int p = 0; p < NP; p++) weights[p*WW +: WW] = WW'(wv[p]);
    endtask

    task automatic add_pkt(input int p, input int len);
        drv_id[p].push_back(next_id);
        drv_len[p].push_back(len);
        mdl_id[p].push_back(next_id);
        mdl_len[p].push_back(len);
        next_id++;
    endtask

    // Whole-packet WRR over the queued packets: predicts the exact egress beat order.
    task automatic model_drain();
        bit elig[NP];
        bit any;
        int sel, id, len;
        forever begin
            any = 0;
            sel = -1;
            for (int p = 0; p < NP; p++) begin
                elig[p] = (mdl_len[p].size() > 0) && (wv[p] != 0);
                any |= elig[p];
            end
            if (!any) break;
            if (elig[m_ptr] && m_burst < wv[m_ptr]) sel = m_ptr;
            else begin
                for (int k = 1; k <= NP; k++)
                    if (sel < 0 && elig[(m_ptr + k) % NP]) sel = (m_ptr + k) % NP;
                m_ptr   = sel;
                m_burst = 0;
            end
            id  = mdl_id[sel].pop_front();
            len = mdl_len[sel].pop_front();
            for (int b = 0; b < len; b++)
                sb.push_back('{mk_data(sel, id, b), mk_keep(id, b == len - 1), mk_user(sel, id, b), b == len - 1, sel});
            m_burst    = (m_burst < 15) ? m_burst + 1 : 15;
            m_cnt[sel] = (m_cnt[sel] + 1) % (1 << CW);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic go();
        model_drain();
        drive_all();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", DW'(sb.size()), DW'(0));
        sb.delete();
        repeat (3) @(posedge clk);
        #2;
        for (int p = 0; p < NP; p++)
            chk($sformatf("pkt_cnt%0d", p), DW'(pkt_cnt[p*CW +: CW]), DW'(m_cnt[p]));
    endtask

    initial begin : driver
        logic [NP-1:0] fire;
        forever begin
            @(negedge clk);
            fire = bus.s_axis_tvalid & bus.s_axis_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (!rst && fire[p] && drv_len[p].size() > 0) begin
                    if (beat_idx[p] == drv_len[p][0] - 1) begin
                        void'(drv_len[p].pop_front());
                        void'(drv_id[p].pop_front());
                        beat_idx[p] = 0;
                    end else beat_idx[p]++;
                end
                bubble[p] = bub_en && (beat_idx[p] > 0) && ($urandom_range(0, 3) == 0);
            end
            case (tr_mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = ($urandom_range(0, 3) != 0);
                default: bus.m_axis_tready = ~bus.m_axis_tready;
            endcase
            drive_all();
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat port=%0d nothing expected (cycle %0d)", grant_id, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("grant_port", DW'(grant_id), DW'(mon_e.port));
                chk("tdata", bus.m_axis_tdata, mon_e.data);
                chk("tkeep", DW'(bus.m_axis_tkeep), DW'(mon_e.keep));
                chk("tuser", DW'(bus.m_axis_tuser), DW'(mon_e.user));
                chk("tlast", DW'(bus.m_axis_tlast), DW'(mon_e.last));
                if (gap_chk) begin
                    if (prev_cyc >= 0) chk("pkt_gap", DW'(cyc - prev_cyc), DW'(2));
                    prev_cyc = cyc;
                end
                beats_seen++;
            end
        end
        if (w2_chk && bus.s_axis_tready[2]) w2_viol++;
    end

    initial begin : main
        int n, base;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
        chk("rst_s_tready", DW'(bus.s_axis_tready), DW'(0));
        chk("rst_grant_id", DW'(grant_id), DW'(0));
        chk("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
        @(negedge clk);
        rst = 1'b0;

        // equal weights, three single-beat packets per port
        sync();
        set_w(1, 1, 1, 1, 1);
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < NP; p++) add_pkt(p, 1);
        go();
        wait_drain(500);

        // 3:1 burst between p0 and p1 with one idle cycle between packets
        sync();
        gap_chk  = 1;
        prev_cyc = -1;
        set_w(3, 1, 1, 1, 1);
        for (int k = 0; k < 8; k++) begin
            add_pkt(0, 1);
            add_pkt(1, 1);
        end
        go();
        wait_drain(500);
        gap_chk = 0;

        // weight 0 keeps a requesting port shut out
        sync();
        w2_chk = 1;
        set_w(1, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) add_pkt(2, 2);
        add_pkt(0, 3);
        add_pkt(4, 1);
        go();
        repeat (1000) @(posedge clk);
        wait_drain(500);
        w2_chk = 0;
        chk("w2_ready_seen", DW'(w2_viol), DW'(0));

        // multi-beat packets under toggling back-pressure with competing requests
        sync();
        tr_mode = 2;
        set_w(2, 2, 1, 1, 1);
        add_pkt(1, 4);
        add_pkt(0, 2);
        add_pkt(0, 3);
        add_pkt(1, 1);
        go();
        wait_drain(500);

        // reset while beat 2 of a 4-beat packet is on the bus
        sync();
        tr_mode = 0;
        set_w(1, 1, 1, 1, 1);
        base = beats_seen;
        add_pkt(3, 4);
        go();
        n = 0;
        while (beats_seen < base + 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_wait_timeout", DW'(beats_seen >= base + 1), DW'(1));
        @(posedge clk);
        #3;
        chk("pre_rst_tvalid", DW'(bus.m_axis_tvalid), DW'(1));
        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            drv_id[p].delete(); drv_len[p].delete(); mdl_id[p].delete(); mdl_len[p].delete();
            beat_idx[p] = 0; bubble[p] = 0; m_cnt[p] = 0;
        end
        sb.delete();
        m_ptr = 0;
        m_burst = 0;
        drive_all();
        #1;
        chk("rst_mid_tvalid", DW'(bus.m_axis_tvalid), DW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("post_rst_grant", DW'(grant_id), DW'(0));
        chk("post_rst_cnt", DW'(pkt_cnt), DW'(0));

        // counter wrap on a narrow counter
        sync();
        tr_mode = 1;
        set_w(15, 1, 1, 1, 1);
        for (int k = 0; k < 18; k++) add_pkt(0, 1);
        go();
        wait_drain(1000);

        // randomized weights, lengths, back-pressure and in-packet bubbles
        bub_en = 1;
        for (int it = 0; it < 6; it++) begin
            sync();
            set_w($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                n = $urandom_range(0, 4);
                for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 4));
            end
            go();
            wait_drain(3000);
        end

        sync();
        set_w(1, 2, 1, 3, 1);
        go();
        wait_drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
